serial_frame_aligner: RTL and testbench



---
 rtl/serial_frame_aligner_pkg.sv | 19 +
 rtl/serial_frame_aligner.sv | 117 +++++++++++
 tb/tb_serial_frame_aligner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_aligner_pkg.sv
// Shared types and header constants for the serial frame aligner.
package serial_frame_aligner_pkg;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    // Wide enough for lock/unlock thresholds of 1..15
    localparam int unsigned MATCH_W = 4;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/serial_frame_aligner.sv
// Serial-to-parallel frame aligner: locks onto a 2-bit sync header per frame
// and emits payload words with data/control qualification once locked.
module serial_frame_aligner
    import serial_frame_aligner_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 3
) (
    input  logic             clk160_i,
    input  logic             rst_n_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] data_o,
    output logic             data_valid_o,
    output logic             ctrl_o,
    output logic             locked_o,
    output logic             slip_o
);

    localparam int unsigned FRAME = WIDTH + 2;
    localparam int unsigned CNT_W = $clog2(FRAME);

    state_t               state_q, state_d;
    logic [FRAME-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MATCH_W-1:0]   good_q, good_d;
    logic [MATCH_W-1:0]   bad_q, bad_d;
    logic [WIDTH-1:0]     data_d;
    logic                 valid_d;
    logic                 ctrl_d;
    logic                 locked_d;
    logic                 slip_d;
    logic [1:0]           hdr;
    logic                 frame_end;

    // State and output registers
    always_ff @(posedge clk160_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_SEARCH;
            sr_q         <= '0;
            cnt_q        <= '0;
            good_q       <= '0;
            bad_q        <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            ctrl_o       <= 1'b0;
            locked_o     <= 1'b0;
            slip_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            data_o       <= data_d;
            data_valid_o <= valid_d;
            ctrl_o       <= ctrl_d;
            locked_o     <= locked_d;
            slip_o       <= slip_d;
        end
    end

    // Frame check operates on the shift register value after this cycle's shift
    always_comb begin
        sr_d      = {sr_q[FRAME-2:0], serial_i};
        hdr       = sr_d[FRAME-1 -: 2];
        frame_end = (cnt_q == CNT_W'(FRAME - 1));

        state_d = state_q;
        cnt_d   = frame_end ? '0 : cnt_q + CNT_W'(1);
        good_d  = good_q;
        bad_d   = bad_q;
        data_d  = data_o;
        ctrl_d  = ctrl_o;
        valid_d = 1'b0;
        slip_d  = 1'b0;

        if (frame_end) begin
            case (state_q)
                ST_SEARCH: begin
                    if (hdr_is_valid(hdr)) begin
                        if (good_q >= MATCH_W'(LOCK_COUNT - 1)) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                            bad_d   = '0;
                        end else if (good_q != '1) begin
                            good_d = good_q + MATCH_W'(1);
                        end
                    end else begin
                        // Move the boundary one bit earlier and restart matching
                        good_d = '0;
                        cnt_d  = CNT_W'(1);
                        slip_d = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (hdr_is_valid(hdr)) begin
                        valid_d = 1'b1;
                        data_d  = sr_d[WIDTH-1:0];
                        ctrl_d  = (hdr == HDR_CTRL);
                        bad_d   = '0;
                    end else if (bad_q >= MATCH_W'(UNLOCK_COUNT - 1)) begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                        bad_d   = '0;
                    end else if (bad_q != '1) begin
                        bad_d = bad_q + MATCH_W'(1);
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

endmodule

// File: tb/tb_serial_frame_aligner.sv
// Directed bench for serial_frame_aligner: reset, aligned/misaligned lock,
// payload output, loss of lock and mid-frame reset.
module tb_serial_frame_aligner;

    logic       clk160_i = 1'b0;
    logic       rst_n_i;
    logic       serial_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       ctrl_o;
    logic       locked_o;
    logic       slip_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int slip_seen    = 0;
    int valid_seen   = 0;

    logic [9:0] cyc [4];

    always #5 clk160_i = ~clk160_i;

    serial_frame_aligner #(
        .WIDTH        (8),
        .LOCK_COUNT   (4),
        .UNLOCK_COUNT (3)
    ) dut (
        .clk160_i     (clk160_i),
        .rst_n_i      (rst_n_i),
        .serial_i     (serial_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .ctrl_o       (ctrl_o),
        .locked_o     (locked_o),
        .slip_o       (slip_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit, clock it in, then sample pulses just after the edge
    task automatic send_bit(input logic b);
        serial_i = b;
        @(posedge clk160_i);
        #1;
        if (slip_o === 1'b1) slip_seen++;
        if (data_valid_o === 1'b1) valid_seen++;
    endtask

    task automatic send_frame(input logic [9:0] f);
        for (int i = 9; i >= 0; i--) send_bit(f[i]);
    endtask

    initial begin
        cyc[0] = {2'b01, 8'hA5};
        cyc[1] = {2'b10, 8'h3C};
        cyc[2] = {2'b01, 8'hF0};
        cyc[3] = {2'b01, 8'h0F};

        // Reset held with random serial input
        rst_n_i  = 1'b0;
        serial_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            serial_i = 1'($urandom);
            @(posedge clk160_i);
            #1;
            if (slip_o === 1'b1) slip_seen++;
        end
        check("rst_data",   32'(data_o),       32'h0);
        check("rst_valid",  32'(data_valid_o), 32'h0);
        check("rst_ctrl",   32'(ctrl_o),       32'h0);
        check("rst_locked", 32'(locked_o),     32'h0);
        check("rst_slips",  32'(slip_seen),    32'd0);
        rst_n_i    = 1'b1;
        slip_seen  = 0;
        valid_seen = 0;

        // Aligned lock
        send_frame(cyc[0]);
        send_frame(cyc[1]);
        send_frame(cyc[2]);
        check("al_prelock", 32'(locked_o), 32'h0);
        send_frame(cyc[3]);
        check("al_locked", 32'(locked_o), 32'h1);
        check("al_slips",  32'(slip_seen),  32'd0);
        check("al_valids", 32'(valid_seen), 32'd0);

        // Post-lock payloads
        send_frame({2'b01, 8'h55});
        check("p55_dv",    32'(data_valid_o), 32'h1);
        check("p55_data",  32'(data_o),       32'h55);
        check("p55_ctrl",  32'(ctrl_o),       32'h0);
        check("p55_count", 32'(valid_seen),   32'd1);
        send_frame({2'b10, 8'hBC});
        check("pbc_data",  32'(data_o),     32'hBC);
        check("pbc_ctrl",  32'(ctrl_o),     32'h1);
        check("pbc_count", 32'(valid_seen), 32'd2);

        // Single invalid header keeps lock and holds outputs
        send_frame({2'b00, 8'h12});
        check("h00_locked", 32'(locked_o),   32'h1);
        check("h00_count",  32'(valid_seen), 32'd2);
        check("h00_hold",   32'(data_o),     32'hBC);
        check("h00_ctrlh",  32'(ctrl_o),     32'h1);
        send_frame({2'b01, 8'h77});
        check("p77_data",   32'(data_o),     32'h77);
        check("p77_count",  32'(valid_seen), 32'd3);
        check("p77_locked", 32'(locked_o),   32'h1);

        // Loss of lock after three bad headers
        send_frame({2'b11, 8'h00});
        send_frame({2'b11, 8'h00});
        check("ul_still", 32'(locked_o), 32'h1);
        send_frame({2'b11, 8'h00});
        check("ul_lost",   32'(locked_o),   32'h0);
        check("ul_count",  32'(valid_seen), 32'd3);
        check("ul_slips",  32'(slip_seen),  32'd0);

        // Relock on aligned stream
        send_frame(cyc[0]);
        send_frame(cyc[1]);
        send_frame(cyc[2]);
        check("rl_prelock", 32'(locked_o), 32'h0);
        send_frame(cyc[3]);
        check("rl_locked", 32'(locked_o),  32'h1);
        check("rl_slips",  32'(slip_seen), 32'd0);
        check("rl_count",  32'(valid_seen), 32'd3);

        // Mid-frame asynchronous reset
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n_i = 1'b0;
        #1;
        check("mr_data",   32'(data_o),       32'h0);
        check("mr_valid",  32'(data_valid_o), 32'h0);
        check("mr_ctrl",   32'(ctrl_o),       32'h0);
        check("mr_locked", 32'(locked_o),     32'h0);
        @(posedge clk160_i);
        #1;
        rst_n_i    = 1'b1;
        slip_seen  = 0;
        valid_seen = 0;
        send_frame(cyc[0]);
        send_frame(cyc[1]);
        send_frame(cyc[2]);
        check("mr_prelock", 32'(locked_o), 32'h0);
        send_frame(cyc[3]);
        check("mr_relock", 32'(locked_o),  32'h1);
        check("mr_slips",  32'(slip_seen), 32'd0);

        // Misaligned lock: stream offset by three zero bits
        rst_n_i = 1'b0;
        @(posedge clk160_i);
        #1;
        rst_n_i    = 1'b1;
        slip_seen  = 0;
        valid_seen = 0;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        for (int k = 0; k < 12; k++) send_frame(cyc[k % 4]);
        check("ma_prelock", 32'(locked_o), 32'h0);
        send_frame(cyc[0]);
        check("ma_locked", 32'(locked_o),   32'h1);
        check("ma_slips",  32'(slip_seen),  32'd7);
        check("ma_valids", 32'(valid_seen), 32'd0);
        send_frame(cyc[1]);
        check("ma_dv",    32'(data_valid_o), 32'h1);
        check("ma_data",  32'(data_o),       32'h3C);
        check("ma_ctrl",  32'(ctrl_o),       32'h1);
        check("ma_count", 32'(valid_seen),   32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
